datamem_pipe: RTL

//  Parametrised, handshaked data memory for the load/store path. Word-addressed synchronous RAM

---
 rtl/datamem_pkg.sv | 27 ++
 rtl/datamem_rsp_fifo.sv | 62 ++++++
 rtl/datamem_pipe.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/datamem_pkg.sv
// Shared defaults, derived widths and parameter legality rules for the load/store data memory.
package datamem_pkg;

  localparam int unsigned DefDataW    = 64;
  localparam int unsigned DefAddrW    = 64;
  localparam int unsigned DefDepth    = 65536;
  localparam int unsigned DefRdLat    = 1;
  localparam int unsigned DefRspDepth = 2;

  // Response fields as seen by the consumer; the data width is supplied by the instantiating
  // module since packages cannot be parameterised.
  typedef struct packed {
    logic we;
    logic err;
  } rsp_flags_t;

  function automatic int unsigned be_w(input int unsigned data_w);
    return data_w / 8;
  endfunction

  function automatic bit params_ok(input int unsigned data_w, input int unsigned rd_lat,
                                   input int unsigned rsp_depth);
    return (data_w != 0) && (data_w % 8 == 0) && (rd_lat == 1 || rd_lat == 2) &&
           (rsp_depth >= 2);
  endfunction

endpackage

// File: rtl/datamem_rsp_fifo.sv
// Synchronous response FIFO with count-based full/empty; a push is accepted while full when the
// same cycle pops, so the head slot can be refilled without a bubble.
module datamem_rsp_fifo #(
  parameter int unsigned Depth = 2,
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             full;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign empty_o = (cnt_q == '0);
  assign full    = (cnt_q == CntW'(Depth));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full || do_pop);
  assign data_o  = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q + CntW'(do_push) - CntW'(do_pop);
    if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: the count alone decides which entries are live.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/datamem_pipe.sv
// Handshaked word-addressed data memory: byte-lane RAM, 1- or 2-cycle read pipeline, in-order
// response queue and a credit counter that bounds outstanding requests to the queue depth.
module datamem_pipe
  import datamem_pkg::*;
#(
  parameter int unsigned DATA_W    = DefDataW,
  parameter int unsigned ADDR_W    = DefAddrW,
  parameter int unsigned DEPTH     = DefDepth,
  parameter int unsigned RD_LAT    = DefRdLat,
  parameter int unsigned RSP_DEPTH = DefRspDepth
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [DATA_W/8-1:0]   req_be,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_we,
  output logic                  rsp_err
);

  localparam int unsigned BeW  = be_w(DATA_W);
  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(RSP_DEPTH + 1);

  if (!params_ok(DATA_W, RD_LAT, RSP_DEPTH)) begin : gen_param_check
    $fatal(1, "datamem_pipe: illegal DATA_W/RD_LAT/RSP_DEPTH combination");
  end

  typedef struct packed {
    logic [DATA_W-1:0] rdata;
    rsp_flags_t        flags;
  } rsp_t;

  logic            ready_en_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            accept;
  logic            in_range;
  logic [IdxW-1:0] idx;
  logic            wr_en;
  logic            rd_en;
  logic [DATA_W-1:0] ram_rdata;

  logic            s1_valid_q, s1_valid_d;
  rsp_flags_t      s1_flags_q, s1_flags_d;
  rsp_t            s1_rsp;
  logic            last_valid;
  rsp_t            last_rsp;

  logic            fifo_empty;
  logic            fifo_push;
  logic            fifo_pop;
  rsp_t            fifo_rsp;
  rsp_t            shown_rsp;
  logic            rsp_hs;

  // Full-width compare so that high address bits can never alias onto a valid word.
  assign in_range = (req_addr < ADDR_W'(DEPTH));
  assign idx      = req_addr[IdxW-1:0];
  assign accept   = req_valid && req_ready;
  assign wr_en    = accept && req_we && in_range;
  assign rd_en    = accept && !req_we && in_range;

  assign req_ready = ready_en_q && (cnt_q < CntW'(RSP_DEPTH));

  // One RAM per byte lane keeps byte-enable writes a plain single-port write per lane.
  for (genvar b = 0; b < BeW; b++) begin : gen_lane
    logic [7:0] lane_mem [DEPTH];
    logic [7:0] lane_rdata_q;

    always_ff @(posedge clk) begin
      if (wr_en && req_be[b]) lane_mem[idx] <= req_wdata[8*b +: 8];
      if (rd_en)              lane_rdata_q  <= lane_mem[idx];
    end

    assign ram_rdata[8*b +: 8] = lane_rdata_q;
  end

  always_comb begin
    s1_valid_d     = accept;
    s1_flags_d.we  = req_we;
    s1_flags_d.err = !in_range;
    cnt_d          = cnt_q + CntW'(accept) - CntW'(rsp_hs);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en_q <= 1'b0;
      cnt_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_flags_q <= '0;
    end else begin
      ready_en_q <= 1'b1;
      cnt_q      <= cnt_d;
      s1_valid_q <= s1_valid_d;
      s1_flags_q <= s1_flags_d;
    end
  end

  // Writes and range errors carry zero data; the RAM output register is only valid for reads.
  always_comb begin
    s1_rsp.flags = s1_flags_q;
    s1_rsp.rdata = (s1_flags_q.we || s1_flags_q.err) ? '0 : ram_rdata;
  end

  if (RD_LAT == 2) begin : gen_lat2
    logic s2_valid_q;
    rsp_t s2_rsp_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s2_valid_q <= 1'b0;
        s2_rsp_q   <= '0;
      end else begin
        s2_valid_q <= s1_valid_q;
        s2_rsp_q   <= s1_rsp;
      end
    end

    assign last_valid = s2_valid_q;
    assign last_rsp   = s2_rsp_q;
  end else begin : gen_lat1
    assign last_valid = s1_valid_q;
    assign last_rsp   = s1_rsp;
  end

  // The pipeline output bypasses the queue when it is empty and the consumer is ready; otherwise
  // it is parked behind older responses. Credits guarantee room for it.
  assign fifo_push = last_valid && !(fifo_empty && rsp_ready);
  assign fifo_pop  = rsp_hs && !fifo_empty;

  datamem_rsp_fifo #(
    .Depth (RSP_DEPTH),
    .Width ($bits(rsp_t))
  ) u_rsp_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .push_i  (fifo_push),
    .data_i  (last_rsp),
    .pop_i   (fifo_pop),
    .data_o  (fifo_rsp),
    .empty_o (fifo_empty)
  );

  always_comb begin
    shown_rsp = '0;
    if (!fifo_empty)     shown_rsp = fifo_rsp;
    else if (last_valid) shown_rsp = last_rsp;
  end

  assign rsp_valid = !fifo_empty || last_valid;
  assign rsp_hs    = rsp_valid && rsp_ready;
  assign rsp_rdata = shown_rsp.rdata;
  assign rsp_we    = shown_rsp.flags.we;
  assign rsp_err   = shown_rsp.flags.err;

endmodule
